// File: rtl/trivium_stream.sv
// trivium_stream: Trivium keystream generator, OUT_W rounds per clock.
// Latency: init_start -> INIT_ROUNDS/OUT_W busy cycles, then one word per cycle.
// Backpressure: ks_ready low holds state and keystream; no words lost.
//
// Ports: clk, rst (sync active-high), init_start (latch key/iv, begin init),
//   key[79:0], iv[79:0], busy (in INIT), ks_valid/ks_ready handshake,
//   keystream[OUT_W-1:0] (bit 0 = earliest round).
// Optional macro TRIVIUM_STREAM_XOR_EN adds din/dout: dout = din ^ keystream
//   while ks_valid, otherwise 0.
module trivium_stream #(
  parameter int OUT_W       = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  output logic             busy,
  output logic             ks_valid,
  input  logic             ks_ready,
`ifdef TRIVIUM_STREAM_XOR_EN
  input  logic [OUT_W-1:0] din,
  output logic [OUT_W-1:0] dout,
`endif
  output logic [OUT_W-1:0] keystream
);

  localparam int INIT_CYC = INIT_ROUNDS / OUT_W;
  localparam int CW       = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(INIT_CYC - 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // st[n-1] holds Trivium state bit s_n.
  logic [287:0]  st, st_nxt;

  // Returns {z, next_state} for one round.
  function automatic logic [288:0] trivium_round(input logic [287:0] s);
    logic t1, t2, t3, z;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  // OUT_W rounds chained combinationally; stage[OUT_W] is the advanced state.
  logic [OUT_W:0][287:0] stage;
  logic [OUT_W-1:0]      z_bits;

  assign stage[0] = st;
  for (genvar g = 0; g < OUT_W; g++) begin : g_round
    assign {z_bits[g], stage[g+1]} = trivium_round(stage[g]);
  end

  logic [287:0] load_val;
  assign load_val = {3'b111, 112'b0, iv, 13'b0, key};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      st    <= st_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    st_nxt    = st;
    busy      = 1'b0;
    ks_valid  = 1'b0;
    case (state)
      IDLE: ;
      INIT: begin
        busy   = 1'b1;
        st_nxt = stage[OUT_W];
        if (cnt == LAST_CNT) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        ks_valid = 1'b1;
        if (ks_ready) st_nxt = stage[OUT_W];
      end
      default: state_nxt = IDLE;
    endcase
    // A new init_start overrides everything; in RUN the word currently shown
    // counts as consumed if ks_ready is high, the state is simply reloaded.
    if (init_start) begin
      st_nxt    = load_val;
      cnt_nxt   = '0;
      state_nxt = INIT;
    end
  end

  assign keystream = ks_valid ? z_bits : '0;

`ifdef TRIVIUM_STREAM_XOR_EN
  assign dout = ks_valid ? (din ^ z_bits) : '0;
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// tb_trivium_stream: directed + randomized checks of trivium_stream against a
// bit-serial Trivium model (1-based state array, one round per step).
// Covers reset, init latency, golden stream, backpressure, restarts, width invariance.
module tb_trivium_stream;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_start = 1'b0;
  logic [79:0] key = '0;
  logic [79:0] iv = '0;
  logic ks_ready = 1'b0;
  logic busy, ks_valid;
  logic [W-1:0] keystream;
  logic [W-1:0] din = '0;
  logic [W-1:0] dout;

  logic busy1, valid1, busy32, valid32;
  logic [0:0]  ks1;
  logic [31:0] ks32;
  logic [0:0]  din1 = '0, dout1;
  logic [31:0] din32 = '0, dout32;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  trivium_stream #(.OUT_W(8)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .key(key), .iv(iv),
    .busy(busy), .ks_valid(ks_valid), .ks_ready(ks_ready),
`ifdef TRIVIUM_STREAM_XOR_EN
    .din(din), .dout(dout),
`endif
    .keystream(keystream));

  trivium_stream #(.OUT_W(1)) dut_w1 (
    .clk(clk), .rst(rst), .init_start(init_start), .key(key), .iv(iv),
    .busy(busy1), .ks_valid(valid1), .ks_ready(1'b1),
`ifdef TRIVIUM_STREAM_XOR_EN
    .din(din1), .dout(dout1),
`endif
    .keystream(ks1));

  trivium_stream #(.OUT_W(32)) dut_w32 (
    .clk(clk), .rst(rst), .init_start(init_start), .key(key), .iv(iv),
    .busy(busy32), .ks_valid(valid32), .ks_ready(1'b1),
`ifdef TRIVIUM_STREAM_XOR_EN
    .din(din32), .dout(dout32),
`endif
    .keystream(ks32));

`ifndef TRIVIUM_STREAM_XOR_EN
  assign dout = '0;
  assign dout1 = '0;
  assign dout32 = '0;
`endif

  // Reference keystream bits for the current key/iv.
  bit ref_q[$];

  function automatic void gen_ref(input logic [79:0] k, input logic [79:0] v, input int nbits);
    bit s[1:288];
    bit t1, t2, t3, z;
    ref_q.delete();
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) s[i] = k[i-1];
    for (int i = 1; i <= 80; i++) s[93+i] = v[i-1];
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + nbits; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      z = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 178; i--) s[i] = s[i-1];
      s[178] = t2;
      for (int i = 177; i > 94; i--) s[i] = s[i-1];
      s[94] = t1;
      for (int i = 93; i > 1; i--) s[i] = s[i-1];
      s[1] = t3;
      if (r >= 1152) ref_q.push_back(z);
    end
  endfunction

  function automatic logic [W-1:0] ref_word(input int idx);
    logic [W-1:0] w;
    for (int k = 0; k < W; k++) w[k] = ref_q[idx*W + k];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_init(input logic [79:0] k, input logic [79:0] v);
    key = k;
    iv = v;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    key = {$urandom, $urandom, $urandom};  // must be ignored from here on
    iv = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (busy && cyc < 3000) begin
      cyc++;
      tick();
    end
  endtask

  // Consume nwords with ks_ready held high, checking each word.
  task automatic check_stream(input string tag, input int nwords);
    logic [W-1:0] exp;
    ks_ready = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      exp = ref_word(i);
      din = (i % 2 == 1) ? 8'hFF : W'($urandom);
      #1;
      chk({tag, "_valid"}, 64'(ks_valid), 64'd1);
      chk({tag, "_ks"}, 64'(keystream), 64'(exp));
`ifdef TRIVIUM_STREAM_XOR_EN
      chk({tag, "_dout"}, 64'(dout), 64'(din ^ exp));
`endif
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 64'(ks_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ks"}, 64'(keystream), 64'd0);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
  endtask

  initial begin
    int cyc, idx;
    logic [79:0] ka, va, kb;
    logic [W-1:0] prev_ks;
    logic prev_rdy;
    logic [1023:0] v1, v8, v32, vexp;
    int n1, n8, n32, bad1, bad8, bad32;
    bit pat[4];

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_idle("reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle_hold");
    end

    // Init latency and golden stream, key=0 iv=0
    gen_ref(80'h0, 80'h0, 64*W);
    pulse_init(80'h0, 80'h0);
    wait_init(cyc);
    chk("init_cycles", 64'(cyc), 64'd144);
    chk("valid_after_init", 64'(ks_valid), 64'd1);
    check_stream("golden0", 64);

    // Restart mid-RUN with ks_ready high, key MSB set
    kb = 80'h80000000000000000000;
    gen_ref(kb, 80'h0, 64*W);
    ks_ready = 1'b1;
    pulse_init(kb, 80'h0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_init(cyc);
    chk("restart_cycles", 64'(cyc), 64'd144);
    check_stream("golden_msb", 64);

    // Backpressure: ks_ready pattern 1,0,0,1 then random
    ka = {$urandom, $urandom, $urandom};
    va = {$urandom, $urandom, $urandom};
    gen_ref(ka, va, 200*W);
    pulse_init(ka, va);
    wait_init(cyc);
    chk("bp_init_cycles", 64'(cyc), 64'd144);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    idx = 0;
    prev_rdy = 1'b1;
    prev_ks = '0;
    for (int i = 0; i < 80; i++) begin
      ks_ready = (i < 40) ? pat[i % 4] : 1'($urandom_range(0, 1));
      chk("bp_ks", 64'(keystream), 64'(ref_word(idx)));
      if (!prev_rdy) chk("bp_hold", 64'(keystream), 64'(prev_ks));
      prev_ks = keystream;
      prev_rdy = ks_ready;
      if (ks_ready) idx++;
      tick();
    end

    // init_start while in INIT restarts the counter and reloads
    pulse_init(ka, va);
    for (int i = 0; i < 50; i++) tick();
    kb = {$urandom, $urandom, $urandom};
    gen_ref(kb, va, 16*W);
    pulse_init(kb, va);
    wait_init(cyc);
    chk("reinit_cycles", 64'(cyc), 64'd144);
    check_stream("reinit", 16);

    // Reset mid-RUN and mid-INIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_run");
    pulse_init(ka, va);
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rst_init");
    tick();
    check_idle("rst_init_hold");

    // Width invariance: OUT_W = 1, 8, 32 against the model
    ka = {$urandom, $urandom, $urandom};
    va = {$urandom, $urandom, $urandom};
    gen_ref(ka, va, 1024);
    for (int i = 0; i < 1024; i++) vexp[i] = ref_q[i];
    ks_ready = 1'b1;
    pulse_init(ka, va);
    v1 = '0; v8 = '0; v32 = '0;
    n1 = 0; n8 = 0; n32 = 0;
    cyc = 0;
    while ((n1 < 1024 || n8 < 1024 || n32 < 1024) && cyc < 4000) begin
      if (valid1 && n1 < 1024) begin v1[n1] = ks1[0]; n1++; end
      if (ks_valid) for (int k = 0; k < 8; k++) if (n8 < 1024) begin v8[n8] = keystream[k]; n8++; end
      if (valid32) for (int k = 0; k < 32; k++) if (n32 < 1024) begin v32[n32] = ks32[k]; n32++; end
      cyc++;
      tick();
    end
    chk("width_timeout", 64'(cyc < 4000), 64'd1);
    bad1 = -1; bad8 = -1; bad32 = -1;
    for (int i = 1023; i >= 0; i--) begin
      if (v1[i] !== vexp[i]) bad1 = i;
      if (v8[i] !== vexp[i]) bad8 = i;
      if (v32[i] !== vexp[i]) bad32 = i;
    end
    chk("width_w1_first_bad_bit", 64'(bad1), 64'(-1));
    chk("width_w8_first_bad_bit", 64'(bad8), 64'(-1));
    chk("width_w32_first_bad_bit", 64'(bad32), 64'(-1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
